// File: rtl/ahb_ext_responder.sv
// AHB-Lite subordinate for the external (HSELEXT) port: byte-strobed RAM with fixed wait states.
// Define AHB_EXT_ERR_EN to enable the ERR_BASE/ERR_SIZE two-cycle ERROR-response window.
module ahb_ext_responder #(
    parameter int          AHBW        = 64,
    parameter int          PA_BITS     = 34,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 0,
    parameter logic [63:0] ERR_BASE    = 64'h0,
    parameter logic [63:0] ERR_SIZE    = 64'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               HSELEXT,
    input  logic [PA_BITS-1:0] HADDR,
    input  logic [1:0]         HTRANS,
    input  logic               HWRITE,
    input  logic [2:0]         HSIZE,
    input  logic               HREADY,
    input  logic [AHBW-1:0]    HWDATA,
    input  logic [AHBW/8-1:0]  HWSTRB,
    output logic [AHBW-1:0]    HRDATAEXT,
    output logic               HREADYEXT,
    output logic               HRESPEXT
);
    localparam int NB    = AHBW / 8;
    localparam int OFS_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA
`ifdef AHB_EXT_ERR_EN
        , S_ERR1
        , S_ERR2
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             wr_q, wr_d;
    logic             ready_q, ready_d;
    logic [AHBW-1:0]  rdata_q, rdata_d;
    logic [AHBW-1:0]  rd_word;
    logic [IDX_W-1:0] acc_idx;
    logic             accept;

    logic [AHBW-1:0]  ram [DEPTH];

    assign acc_idx = HADDR[OFS_W +: IDX_W];
    assign accept  = HSELEXT & HTRANS[1] & HREADY;

`ifdef AHB_EXT_ERR_EN
    logic        err_q, err_d;
    logic        resp_q, resp_d;
    logic        acc_err;
    logic [63:0] haddr64;

    assign haddr64 = 64'(HADDR);
    assign acc_err = (haddr64 >= ERR_BASE) && (haddr64 < ERR_BASE + ERR_SIZE);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
`ifdef AHB_EXT_ERR_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'(WAIT_STATES)) begin
                    cnt_d = 4'd0;
`ifdef AHB_EXT_ERR_EN
                    state_d = err_q ? S_ERR1 : S_DATA;
`else
                    state_d = S_DATA;
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
`ifdef AHB_EXT_ERR_EN
            S_ERR1: state_d = S_ERR2;
`endif
            // IDLE, DATA and ERR2 are the cycles where HREADYEXT is high, so a new
            // address phase can be taken here (pipelined when coming from DATA/ERR2).
            default: begin
                if (accept) begin
                    idx_d = acc_idx;
                    wr_d  = HWRITE;
`ifdef AHB_EXT_ERR_EN
                    err_d = acc_err;
`endif
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'd1;
                    end else begin
`ifdef AHB_EXT_ERR_EN
                        state_d = acc_err ? S_ERR1 : S_DATA;
`else
                        state_d = S_DATA;
`endif
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // A write closing on the same edge that opens a read of the same word has not
    // reached the RAM yet, so merge its strobed bytes into the read data.
    always_comb begin
        rd_word = ram[idx_d];
        if (state_q == S_DATA && wr_q && idx_q == idx_d) begin
            for (int b = 0; b < NB; b++) begin
                if (HWSTRB[b]) rd_word[b*8 +: 8] = HWDATA[b*8 +: 8];
            end
        end
    end

    always_comb begin
        ready_d = (state_d != S_WAIT);
        rdata_d = '0;
        if (state_d == S_DATA && !wr_d) rdata_d = rd_word;
`ifdef AHB_EXT_ERR_EN
        if (state_d == S_ERR1) ready_d = 1'b0;
        resp_d = (state_d == S_ERR1) || (state_d == S_ERR2);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            ready_q <= 1'b1;
            rdata_q <= '0;
`ifdef AHB_EXT_ERR_EN
            err_q   <= 1'b0;
            resp_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
`ifdef AHB_EXT_ERR_EN
            err_q   <= err_d;
            resp_q  <= resp_d;
`endif
        end
    end

    // Error-region writes never reach DATA, so they never commit.
    always_ff @(posedge clk) begin
        if (!reset && state_q == S_DATA && wr_q) begin
            for (int b = 0; b < NB; b++) begin
                if (HWSTRB[b]) ram[idx_q][b*8 +: 8] <= HWDATA[b*8 +: 8];
            end
        end
    end

    assign HRDATAEXT = rdata_q;
    assign HREADYEXT = ready_q;
`ifdef AHB_EXT_ERR_EN
    assign HRESPEXT  = resp_q;
`else
    assign HRESPEXT  = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{HSIZE, HTRANS[0], HADDR, ERR_BASE, ERR_SIZE};

endmodule
